// File: rtl/fht_io_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fht_io_sequencer
//  Description : Frame sequencer for the FHT core. Streams N = 4*2^A_BIT
//                samples into the four RAM banks, kicks fht_control, waits
//                for the transform, then streams the results back out.
//  Revision    : 1.0 - initial release
// ============================================================================
module fht_io_sequencer #(
    parameter int A_BIT   = 8,
    parameter int D_BIT   = 16,
    parameter bit OUT_SET = 1'b0
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iIN_VALID,
    input  logic [D_BIT-1:0]   iIN_DATA,
    output logic               oIN_READY,
    output logic [A_BIT-1:0]   oWR_ADDR,
    output logic [D_BIT-1:0]   oWR_DATA,
    output logic [3:0]         oWE_BANK,
    output logic [A_BIT-1:0]   oRD_ADDR,
    input  logic [4*D_BIT-1:0] iRD_DATA,
    output logic               oSET,
    output logic               oMEM_OWNER,
    output logic               oFHT_START,
    input  logic               iFHT_RDY,
    input  logic               iABORT,
    output logic               oOUT_VALID,
    output logic [D_BIT-1:0]   oOUT_DATA,
    output logic               oOUT_LAST,
    input  logic               iOUT_READY,
    output logic               oBUSY,
    output logic               oDONE
);

    localparam int               P_BIT        = A_BIT + 2;
    localparam logic [P_BIT-1:0] c_PTR_LAST   = {P_BIT{1'b1}};
    localparam logic [P_BIT-1:0] c_PTR_ONE    = {{(P_BIT-1){1'b0}}, 1'b1};
    localparam logic [1:0]       c_WAIT_LIMIT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_RUN       = 3'd4,
        S_PRIME     = 3'd5,
        S_UNLOAD    = 3'd6
    } t_state;

    t_state           r_state,     w_state_nxt;
    logic [P_BIT-1:0] r_ptr,       w_ptr_nxt;
    logic [A_BIT-1:0] r_wr_addr,   w_wr_addr_nxt;
    logic [D_BIT-1:0] r_wr_data,   w_wr_data_nxt;
    logic [3:0]       r_we_bank,   w_we_bank_nxt;
    logic             r_start,     w_start_nxt;
    logic             r_owner,     w_owner_nxt;
    logic             r_set,       w_set_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic             r_done,      w_done_nxt;
    logic [1:0]       r_wait_cnt,  w_wait_cnt_nxt;
    logic             r_repulsed,  w_repulsed_nxt;

    logic             w_fire;
    logic [P_BIT-1:0] w_ptr_inc;
    logic [P_BIT-1:0] w_rd_ptr;
    logic [D_BIT-1:0] w_bank_data;

    assign w_fire    = r_out_valid & iOUT_READY;
    assign w_ptr_inc = r_ptr + c_PTR_ONE;
    // Read pointer looks one sample ahead on a fire so the 1-cycle RAM keeps up.
    assign w_rd_ptr  = w_fire ? w_ptr_inc : r_ptr;

    // Select the bank that holds the current pointer's sample.
    always_comb begin
        w_bank_data = iRD_DATA[D_BIT-1:0];
        case (r_ptr[1:0])
            2'd1:    w_bank_data = iRD_DATA[1*D_BIT +: D_BIT];
            2'd2:    w_bank_data = iRD_DATA[2*D_BIT +: D_BIT];
            2'd3:    w_bank_data = iRD_DATA[3*D_BIT +: D_BIT];
            default: w_bank_data = iRD_DATA[D_BIT-1:0];
        endcase
    end

    // Next-state and next-output logic for the whole frame sequence.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_we_bank_nxt   = 4'b0000;
        w_start_nxt     = 1'b0;
        w_owner_nxt     = r_owner;
        w_set_nxt       = r_set;
        w_out_valid_nxt = r_out_valid;
        w_done_nxt      = 1'b0;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_repulsed_nxt  = r_repulsed;

        case (r_state)
            S_IDLE, S_LOAD: begin
                if ((r_state == S_LOAD) && iABORT) begin
                    // A handshake in the abort cycle is dropped, not written.
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = '0;
                end else if (iIN_VALID) begin
                    w_we_bank_nxt = 4'b0001 << r_ptr[1:0];
                    w_wr_addr_nxt = r_ptr[P_BIT-1:2];
                    w_wr_data_nxt = iIN_DATA;
                    if (r_ptr == c_PTR_LAST) begin
                        w_state_nxt = S_START;
                        w_ptr_nxt   = '0;
                    end else begin
                        w_state_nxt = S_LOAD;
                        w_ptr_nxt   = w_ptr_inc;
                    end
                end
            end
            S_START: begin
                w_start_nxt    = 1'b1;
                w_owner_nxt    = 1'b1;
                w_wait_cnt_nxt = 2'd0;
                w_repulsed_nxt = 1'b0;
                w_state_nxt    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!iFHT_RDY) begin
                    w_state_nxt = S_RUN;
                end else if (!r_repulsed) begin
                    // Engine missed the first pulse: retry exactly once.
                    if (r_wait_cnt == c_WAIT_LIMIT) begin
                        w_start_nxt    = 1'b1;
                        w_repulsed_nxt = 1'b1;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + 2'd1;
                    end
                end
            end
            S_RUN: begin
                if (iFHT_RDY) begin
                    w_owner_nxt = 1'b0;
                    w_set_nxt   = OUT_SET;
                    w_ptr_nxt   = '0;
                    w_state_nxt = S_PRIME;
                end
            end
            S_PRIME: begin
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = S_UNLOAD;
            end
            S_UNLOAD: begin
                if (iABORT) begin
                    w_state_nxt     = S_IDLE;
                    w_ptr_nxt       = '0;
                    w_out_valid_nxt = 1'b0;
                    w_set_nxt       = 1'b0;
                end else if (w_fire) begin
                    if (r_ptr == c_PTR_LAST) begin
                        w_state_nxt     = S_IDLE;
                        w_ptr_nxt       = '0;
                        w_out_valid_nxt = 1'b0;
                        w_set_nxt       = 1'b0;
                        w_done_nxt      = 1'b1;
                    end else begin
                        w_ptr_nxt = w_ptr_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset returns everything to idle.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_we_bank   <= 4'b0000;
            r_start     <= 1'b0;
            r_owner     <= 1'b0;
            r_set       <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_wait_cnt  <= 2'd0;
            r_repulsed  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_we_bank   <= w_we_bank_nxt;
            r_start     <= w_start_nxt;
            r_owner     <= w_owner_nxt;
            r_set       <= w_set_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_done      <= w_done_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_repulsed  <= w_repulsed_nxt;
        end
    end

    assign oIN_READY  = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign oWR_ADDR   = r_wr_addr;
    assign oWR_DATA   = r_wr_data;
    assign oWE_BANK   = r_we_bank;
    assign oRD_ADDR   = w_rd_ptr[P_BIT-1:2];
    assign oSET       = r_set;
    assign oMEM_OWNER = r_owner;
    assign oFHT_START = r_start;
    assign oOUT_VALID = r_out_valid;
    assign oOUT_DATA  = w_bank_data;
    assign oOUT_LAST  = r_out_valid && (r_ptr == c_PTR_LAST);
    assign oBUSY      = (r_state != S_IDLE);
    assign oDONE      = r_done;

endmodule
`default_nettype wire
